// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the AHB master and slaves of this IP.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    // NONSEQ and SEQ are the only transfer types that open a data phase.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port word memory: synchronous write, combinational read, no reset.
module sram_1rw #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] words [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] word_reg;

            always_ff @(posedge clk) begin
                if (we && (addr == ADDR_W'(gi))) begin
                    word_reg <= wdata;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    assign rdata = words[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave fronting a word-addressed register file, with programmable
// wait states, two-cycle ERROR responses for illegal beats and write-to-read forwarding.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_hsel,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [1:0]            i_htrans,
    input  logic                  i_hwrite,
    input  logic [2:0]            i_hsize,
    input  logic [2:0]            i_hburst,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    input  logic                  i_hready,
    output logic                  o_hreadyout,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_hresp,
    output logic [7:0]            o_err_count
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [2:0] D_IDLE = 3'd0;
    localparam logic [2:0] D_WAIT = 3'd1;
    localparam logic [2:0] D_DATA = 3'd2;
    localparam logic [2:0] D_ERR1 = 3'd3;
    localparam logic [2:0] D_ERR2 = 3'd4;

    logic [2:0]            state_reg, state_next;
    logic [2:0]            wait_cnt_reg, wait_cnt_next;
    logic [IDX_W-1:0]      idx_reg;
    logic                  write_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [7:0]            err_count_reg;
    logic                  fwd_valid_reg;
    logic [IDX_W-1:0]      fwd_idx_reg;
    logic [DATA_WIDTH-1:0] fwd_data_reg;

    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      addr_idx;
    logic                  in_window;
    logic                  legal;
    logic                  addr_phase_open;
    logic                  take;
    logic [2:0]            dispatch_state;
    logic                  write_beat;
    logic                  read_beat;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] read_word;
    logic                  unused_inputs;

    // Bursts carry their own address per beat and are never wrapped here.
    assign unused_inputs = ^i_hburst;

    // Window is aligned to its size, so anything below BASE wraps to a large offset.
    assign offset    = i_haddr - BASE_ADDR;
    assign addr_idx  = offset[IDX_W+1:2];
    assign in_window = (offset[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign legal     = (i_hsize == HSIZE_WORD) && (i_haddr[1:0] == 2'b00) && in_window;

    // A new address phase is only sampled while the slave is driving hreadyout high.
    assign addr_phase_open = (state_reg == D_IDLE) || (state_reg == D_DATA) || (state_reg == D_ERR2);
    assign take            = i_hsel && i_hready && htrans_active(i_htrans) && addr_phase_open;

    always_comb begin
        dispatch_state = D_IDLE;
        if (take) begin
            if (!legal) begin
                dispatch_state = D_ERR1;
            end else if (WAIT_STATES == 0) begin
                dispatch_state = D_DATA;
            end else begin
                dispatch_state = D_WAIT;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            D_IDLE, D_DATA, D_ERR2: begin
                state_next = dispatch_state;
                if (dispatch_state == D_WAIT) begin
                    wait_cnt_next = 3'(WAIT_STATES);
                end
            end
            D_WAIT: begin
                wait_cnt_next = wait_cnt_reg - 3'd1;
                if (wait_cnt_reg == 3'd1) begin
                    state_next = D_DATA;
                end
            end
            D_ERR1:  state_next = D_ERR2;
            default: state_next = D_IDLE;
        endcase
    end

    assign write_beat = (state_reg == D_DATA) && write_reg;
    assign read_beat  = (state_reg == D_DATA) && !write_reg;

    sram_1rw #(
        .DEPTH  (MEM_DEPTH),
        .WIDTH  (DATA_WIDTH),
        .ADDR_W (IDX_W)
    ) u_mem (
        .clk   (i_clk),
        .we    (write_beat),
        .addr  (idx_reg),
        .wdata (i_hwdata),
        .rdata (mem_rdata)
    );

    // Keeps read-after-write correct even if the memory is swapped for one with write latency.
    assign read_word = (fwd_valid_reg && (fwd_idx_reg == idx_reg)) ? fwd_data_reg : mem_rdata;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= D_IDLE;
            wait_cnt_reg  <= '0;
            idx_reg       <= '0;
            write_reg     <= 1'b0;
            rdata_reg     <= '0;
            err_count_reg <= '0;
            fwd_valid_reg <= 1'b0;
            fwd_idx_reg   <= '0;
            fwd_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (take) begin
                idx_reg   <= addr_idx;
                write_reg <= i_hwrite;
            end
            if (read_beat) begin
                rdata_reg <= read_word;
            end
            if ((state_reg == D_ERR1) && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
            fwd_valid_reg <= write_beat;
            if (write_beat) begin
                fwd_idx_reg  <= idx_reg;
                fwd_data_reg <= i_hwdata;
            end
        end
    end

    assign o_hreadyout = !((state_reg == D_WAIT) || (state_reg == D_ERR1));
    assign o_hresp     = ((state_reg == D_ERR1) || (state_reg == D_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign o_hrdata    = read_beat ? read_word : rdata_reg;
    assign o_err_count = err_count_reg;

endmodule
